// File: rtl/sdram_dev_responder_if.sv
// SDRAM pin bundle between a memory controller and the device-side responder.
interface sdram_dev_responder_if #(
    parameter int DATA_BITS = 16
);
    logic                   sdram_cke;
    logic                   sdram_cs_n;
    logic                   sdram_ras_n;
    logic                   sdram_cas_n;
    logic                   sdram_we_n;
    logic [1:0]             sdram_bank;
    logic [12:0]            sdram_addr;
    logic [DATA_BITS/8-1:0] sdram_dqm;
    logic [DATA_BITS-1:0]   dq_in;
    logic [DATA_BITS-1:0]   dq_out;
    logic                   dq_oe;

    modport master (
        output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        output sdram_bank, sdram_addr, sdram_dqm, dq_in,
        input  dq_out, dq_oe
    );

    modport slave (
        input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        input  sdram_bank, sdram_addr, sdram_dqm, dq_in,
        output dq_out, dq_oe
    );
endinterface

// File: rtl/sdram_dev_responder.sv
// Device-side SDRAM responder. Decodes controller commands, tracks open rows
// and the mode register, stores write bursts in an on-chip RAM and returns
// read bursts after the programmed CAS latency. Controller misuse is latched
// into sticky error flags.
module sdram_dev_responder #(
    parameter int COL_BITS  = 9,
    parameter int DATA_BITS = 16,
    parameter int MEM_AW    = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    sdram_dev_responder_if.slave  bus,
    output logic                  mode_valid,
    output logic [3:0]            err,
    output logic [15:0]           refresh_cnt
);

    localparam int ROW_BITS = 13;
    localparam int LANES    = DATA_BITS / 8;

    typedef enum logic [2:0] {
        CMD_LMR = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_BST = 3'b110,
        CMD_NOP = 3'b111
    } cmd_t;

    // Mode register: burst mask (BL-1), full-page flag, CL3 (else CL2)
    logic [COL_BITS-1:0]  mode_mask;
    logic                 mode_full;
    logic                 mode_cl3;

    logic [3:0]           bank_open;
    logic [ROW_BITS-1:0]  bank_row [4];

    // Burst in progress: word 0 is issued with the command, burst_cnt is the next word index
    logic                 burst_active;
    logic                 burst_write;
    logic                 burst_full;
    logic                 burst_ap;
    logic [1:0]           burst_bank;
    logic [ROW_BITS-1:0]  burst_row;
    logic [COL_BITS-1:0]  burst_col;
    logic [COL_BITS-1:0]  burst_cnt;
    logic [COL_BITS-1:0]  burst_mask;

    // Read address pipeline ahead of the output register
    logic                 s1_valid;
    logic                 s2_valid;
    logic [MEM_AW-1:0]    s1_idx;
    logic [MEM_AW-1:0]    s2_idx;
    logic                 out_valid;
    logic [MEM_AW-1:0]    out_idx;
    logic [DATA_BITS-1:0] dq_q;
    logic                 oe_q;

    logic [DATA_BITS-1:0] mem [2**MEM_AW];

    cmd_t                 cmd;
    logic [1:0]           cmd_bank;
    logic [COL_BITS-1:0]  cmd_col;
    logic                 ap_flag;
    logic                 rw_accept;
    logic                 interrupt;
    logic                 burst_step;
    logic                 burst_last;
    logic [COL_BITS-1:0]  step_col;
    logic                 issue_valid;
    logic                 issue_write;
    logic [1:0]           issue_bank;
    logic [ROW_BITS-1:0]  issue_row;
    logic [COL_BITS-1:0]  issue_col;
    logic [MEM_AW-1:0]    issue_idx;
    logic                 wr_en;
    logic                 cmd_ap_close;
    logic                 burst_ap_close;
    logic                 lmr_ok;
    logic [COL_BITS-1:0]  lmr_mask;
    logic                 lmr_full;

    assign bus.dq_out = dq_q;
    assign bus.dq_oe  = oe_q;

    assign cmd_bank = bus.sdram_bank;
    assign cmd_col  = bus.sdram_addr[COL_BITS-1:0];
    assign ap_flag  = bus.sdram_addr[10];

    // Command decode; deselect and clock suspend both look like NOP
    always_comb begin
        cmd = CMD_NOP;
        if (bus.sdram_cke && !bus.sdram_cs_n)
            cmd = cmd_t'({bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n});
    end

    assign rw_accept  = (cmd == CMD_RD || cmd == CMD_WR) && mode_valid && bank_open[cmd_bank];
    assign interrupt  = burst_active &&
                        (rw_accept || cmd == CMD_BST ||
                         (cmd == CMD_PRE && (ap_flag || cmd_bank == burst_bank)));
    assign burst_step = bus.sdram_cke && burst_active && !interrupt;
    assign burst_last = burst_step && !burst_full && (burst_cnt == burst_mask);
    assign step_col   = (burst_col & ~burst_mask) | ((burst_col + burst_cnt) & burst_mask);

    assign cmd_ap_close   = rw_accept && ap_flag && (mode_mask == '0) && !mode_full;
    assign burst_ap_close = burst_last && burst_ap;

    // Pick the word being transferred this edge: a fresh command wins over a running burst
    always_comb begin
        issue_valid = 1'b0;
        issue_write = burst_write;
        issue_bank  = burst_bank;
        issue_row   = burst_row;
        issue_col   = step_col;
        if (rw_accept) begin
            issue_valid = 1'b1;
            issue_write = (cmd == CMD_WR);
            issue_bank  = cmd_bank;
            issue_row   = bank_row[cmd_bank];
            issue_col   = cmd_col;
        end else if (burst_step) begin
            issue_valid = 1'b1;
        end
    end

    assign issue_idx = MEM_AW'({issue_bank, issue_row, issue_col});
    assign wr_en     = !rst && issue_valid && issue_write;
    assign out_valid = mode_cl3 ? s2_valid : s1_valid;
    assign out_idx   = mode_cl3 ? s2_idx : s1_idx;

    // Check a LOAD MODE word: sequential BL 1/2/4/8/page, CL 2 or 3, all banks idle
    always_comb begin
        lmr_ok   = 1'b1;
        lmr_mask = '0;
        lmr_full = 1'b0;
        case (bus.sdram_addr[2:0])
            3'b000:  lmr_mask = COL_BITS'(0);
            3'b001:  lmr_mask = COL_BITS'(1);
            3'b010:  lmr_mask = COL_BITS'(3);
            3'b011:  lmr_mask = COL_BITS'(7);
            3'b111: begin
                lmr_mask = '1;
                lmr_full = 1'b1;
            end
            default: lmr_ok = 1'b0;
        endcase
        if (bus.sdram_addr[3])
            lmr_ok = 1'b0;
        if (bus.sdram_addr[6:4] != 3'd2 && bus.sdram_addr[6:4] != 3'd3)
            lmr_ok = 1'b0;
        if (|bank_open)
            lmr_ok = 1'b0;
    end

    // Backing RAM write port with per-byte masking; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (!bus.sdram_dqm[i])
                    mem[issue_idx][i*8 +: 8] <= bus.dq_in[i*8 +: 8];
            end
        end
    end

    // Protocol state, burst sequencing and read pipeline; everything holds while cke is low
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_mask    <= '0;
            mode_full    <= 1'b0;
            mode_cl3     <= 1'b1;
            mode_valid   <= 1'b0;
            err          <= '0;
            refresh_cnt  <= '0;
            bank_open    <= '0;
            burst_active <= 1'b0;
            burst_write  <= 1'b0;
            burst_full   <= 1'b0;
            burst_ap     <= 1'b0;
            burst_bank   <= '0;
            burst_row    <= '0;
            burst_col    <= '0;
            burst_cnt    <= '0;
            burst_mask   <= '0;
            s1_valid     <= 1'b0;
            s2_valid     <= 1'b0;
            s1_idx       <= '0;
            s2_idx       <= '0;
            dq_q         <= '0;
            oe_q         <= 1'b0;
        end else if (bus.sdram_cke) begin
            s1_valid <= issue_valid && !issue_write;
            s1_idx   <= issue_idx;
            s2_valid <= s1_valid;
            s2_idx   <= s1_idx;
            oe_q     <= out_valid;
            if (out_valid)
                dq_q <= mem[out_idx];

            if (rw_accept) begin
                burst_active <= (mode_mask != '0);
                burst_write  <= (cmd == CMD_WR);
                burst_full   <= mode_full;
                burst_ap     <= ap_flag;
                burst_bank   <= cmd_bank;
                burst_row    <= bank_row[cmd_bank];
                burst_col    <= cmd_col;
                burst_cnt    <= COL_BITS'(1);
                burst_mask   <= mode_mask;
            end else if (interrupt || burst_last) begin
                burst_active <= 1'b0;
            end else if (burst_step) begin
                burst_cnt <= burst_cnt + 1'b1;
            end

            if (burst_ap_close)
                bank_open[burst_bank] <= 1'b0;
            if (cmd_ap_close)
                bank_open[cmd_bank] <= 1'b0;

            case (cmd)
                CMD_LMR: begin
                    if (lmr_ok) begin
                        mode_mask  <= lmr_mask;
                        mode_full  <= lmr_full;
                        mode_cl3   <= (bus.sdram_addr[6:4] == 3'd3);
                        mode_valid <= 1'b1;
                    end else begin
                        err[3] <= 1'b1;
                    end
                end
                CMD_REF: begin
                    if (refresh_cnt != 16'hFFFF)
                        refresh_cnt <= refresh_cnt + 16'd1;
                    if (|bank_open)
                        err[2] <= 1'b1;
                end
                CMD_PRE: begin
                    if (ap_flag)
                        bank_open <= '0;
                    else
                        bank_open[cmd_bank] <= 1'b0;
                end
                CMD_ACT: begin
                    if (bank_open[cmd_bank]) begin
                        err[1] <= 1'b1;
                    end else begin
                        bank_open[cmd_bank] <= 1'b1;
                        bank_row[cmd_bank]  <= bus.sdram_addr;
                    end
                end
                CMD_WR, CMD_RD: begin
                    if (!mode_valid)
                        err[3] <= 1'b1;
                    if (!bank_open[cmd_bank])
                        err[0] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
